// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle shared between the four requesters and the mux arbiter.
// Requesters sit on the master side; the arbiter is the slave.
interface mux4_rr_arbiter_if;
  logic [3:0] REQ;
  logic [3:0] DIN;
  logic [3:0] GNT;
  logic       S1;
  logic       S0;
  logic       VALID;
  logic       Y;

  modport master (output REQ, output DIN, input GNT, input S1, input S0, input VALID, input Y);
  modport slave  (input REQ, input DIN, output GNT, output S1, output S0, output VALID, output Y);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 single-bit mux: registered one-hot grant,
// registered selects, and the selected source bit presented on Y.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    last_reg, last_next;
  logic [1:0]    sel_reg, sel_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [3:0]    gnt_reg, gnt_next;
  logic          valid_reg, valid_next;
  logic          new_grant;

  // In BUSY the owner is always last_reg, so it is excluded from the search.
  logic [1:0] cand_idx [4];
  logic [3:0] cand_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = last_reg + 2'(gi + 1);
      assign cand_ok[gi]  = bus.REQ[cand_idx[gi]] &&
                            !((state_reg == BUSY) && (cand_idx[gi] == last_reg));
    end
  endgenerate

  logic       win_found;
  logic [1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand_ok[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 2'd3;
      sel_reg   <= 2'd0;
      hold_reg  <= '0;
      gnt_reg   <= 4'b0000;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      hold_reg  <= hold_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    new_grant  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = BUSY;
          last_next  = win_idx;
          new_grant  = 1'b1;
        end
      end
      BUSY: begin
        if (!bus.REQ[last_reg]) begin
          if (win_found) begin
            last_next = win_idx;
            new_grant = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if ((hold_reg == HOLD_LAST) && win_found) begin
          last_next = win_idx;
          new_grant = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and hold counter
  always_comb begin
    gnt_next   = (state_next == BUSY) ? (4'b0001 << last_next) : 4'b0000;
    valid_next = (state_next == BUSY);
    sel_next   = new_grant ? last_next : sel_reg;
    hold_next  = hold_reg;
    if (new_grant) begin
      hold_next = '0;
    end else if ((state_reg == BUSY) && (hold_reg != HOLD_LAST)) begin
      hold_next = hold_reg + HW'(1);
    end
  end

  assign bus.GNT   = gnt_reg;
  assign bus.S1    = sel_reg[1];
  assign bus.S0    = sel_reg[0];
  assign bus.VALID = valid_reg;
  assign bus.Y     = valid_reg & bus.DIN[sel_reg];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic, each cycle
// compared against an owner/held-cycles reference model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;
  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: owner (-1 = idle), last owner, displayed select, cycles held
  int m_owner, m_last, m_sel, m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_held  = 0;
  endtask

  function automatic int rr_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last + k) % 4;
      if (i != m_owner && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_held  = 1;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int w;
    w = rr_pick(r);
    if (m_owner < 0) begin
      if (w >= 0) model_grant(w);
    end else if (!r[m_owner]) begin
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else if (m_held >= MAX_HOLD && w >= 0) begin
      model_grant(w);
    end else begin
      m_held++;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    logic       ev, ey;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ev = (m_owner >= 0);
    ey = ev ? bus.DIN[m_sel] : 1'b0;
    check("gnt",    32'(bus.GNT), 32'(eg));
    check("sel",    32'({bus.S1, bus.S0}), 32'(m_sel));
    check("valid",  32'(bus.VALID), 32'(ev));
    check("y",      32'(bus.Y), 32'(ey));
    check("onehot", 32'($onehot0(bus.GNT)), 32'd1);
  endtask

  // One clock: advance the model on the edge, then compare 1ns after it.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_edge(bus.REQ);
    #1;
    $display("cyc=%0d rst=%b REQ=%b DIN=%b GNT=%b S=%b%b VALID=%b Y=%b",
             cyc, rst, bus.REQ, bus.DIN, bus.GNT, bus.S1, bus.S0, bus.VALID, bus.Y);
    check_model();
  endtask

  task automatic async_reset_pulse();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_gnt",   32'(bus.GNT), 32'd0);
    check("arst_valid", 32'(bus.VALID), 32'd0);
    check("arst_y",     32'(bus.Y), 32'd0);
    check("arst_sel",   32'({bus.S1, bus.S0}), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst     = 1'b1;
    bus.REQ = 4'b1111;
    bus.DIN = 4'b1111;

    // Reset held with everything requesting
    repeat (3) step();
    check("rst_gnt", 32'(bus.GNT), 32'd0);
    rst     = 1'b0;
    bus.REQ = 4'b0000;
    step();

    // Single request and release
    bus.REQ = 4'b0100;
    bus.DIN = 4'b0100;
    step();
    check("single_gnt", 32'(bus.GNT), 32'b0100);
    check("single_y",   32'(bus.Y), 32'd1);
    step();
    bus.REQ = 4'b0000;
    step();
    check("release_gnt", 32'(bus.GNT), 32'd0);
    check("release_sel", 32'({bus.S1, bus.S0}), 32'b10);

    // Full contention from a fresh pointer
    async_reset_pulse();
    bus.REQ = 4'b1111;
    bus.DIN = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      step();
      check("contend_gnt", 32'(bus.GNT), 32'(1 << ((k / 4) % 4)));
    end

    // Early release with no gap
    async_reset_pulse();
    bus.REQ = 4'b0011;
    step();
    check("early_first", 32'(bus.GNT), 32'b0001);
    step();
    bus.REQ = 4'b0010;
    step();
    check("early_next",  32'(bus.GNT), 32'b0010);
    check("early_valid", 32'(bus.VALID), 32'd1);

    // Solo owner, then contention forces rotation
    bus.REQ = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k > 0) check("solo_gnt", 32'(bus.GNT), 32'b1000);
    end
    bus.REQ = 4'b1001;
    step();
    check("solo_rotate", 32'(bus.GNT), 32'b0001);

    // Async reset while index 2 owns the mux
    bus.REQ = 4'b0100;
    step();
    check("mid_owner", 32'(bus.GNT), 32'b0100);
    async_reset_pulse();
    bus.REQ = 4'b1111;
    step();
    check("post_rst_gnt", 32'(bus.GNT), 32'b0001);

    // Random traffic with occasional async reset
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) bus.REQ = 4'($urandom);
      bus.DIN = 4'($urandom);
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
